// File: rtl/instruction_serializer_pkg.sv
// Shared definitions for the 8051 instruction byte serializer: FSM state
// encoding, instruction length codes, MCS-51 opcode constants and the
// checksum helper used when INST_SERIALIZER_CHECKSUM_EN is defined.
package instruction_serializer_pkg;

    // ST_CHK is only entered when the checksum byte is configured in.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_B0   = 3'd1,
        ST_B1   = 3'd2,
        ST_B2   = 3'd3,
        ST_CHK  = 3'd4
    } ser_state_e;

    // LEN_0 is what the length output shows while nothing is in flight.
    localparam logic [1:0] LEN_0 = 2'd0;
    localparam logic [1:0] LEN_1 = 2'd1;
    localparam logic [1:0] LEN_2 = 2'd2;
    localparam logic [1:0] LEN_3 = 2'd3;

    // General MCS-51 opcodes referenced by the loader and trace tooling.
    localparam logic [7:0] OP_NOP        = 8'h00;
    localparam logic [7:0] OP_AJMP_PAGE0 = 8'h01;
    localparam logic [7:0] OP_ACALL_PAGE0 = 8'h11;
    localparam logic [7:0] OP_SJMP       = 8'h80;
    localparam logic [7:0] OP_MOV_A_IMM  = 8'h74;
    localparam logic [7:0] OP_RESERVED   = 8'hA5;
    localparam logic [7:0] OP_CLR_A      = 8'hE4;

    // Three-byte instructions (CJNE occupies the whole 0xB4-0xBF block).
    localparam logic [7:0] OP_LJMP         = 8'h02;
    localparam logic [7:0] OP_JBC          = 8'h10;
    localparam logic [7:0] OP_LCALL        = 8'h12;
    localparam logic [7:0] OP_JB           = 8'h20;
    localparam logic [7:0] OP_JNB          = 8'h30;
    localparam logic [7:0] OP_ORL_DIR_IMM  = 8'h43;
    localparam logic [7:0] OP_ANL_DIR_IMM  = 8'h53;
    localparam logic [7:0] OP_XRL_DIR_IMM  = 8'h63;
    localparam logic [7:0] OP_MOV_DIR_IMM  = 8'h75;
    localparam logic [7:0] OP_MOV_DIR_DIR  = 8'h85;
    localparam logic [7:0] OP_MOV_DPTR_IMM = 8'h90;
    localparam logic [7:0] OP_CJNE_FIRST   = 8'hB4;
    localparam logic [7:0] OP_CJNE_LAST    = 8'hBF;
    localparam logic [7:0] OP_DJNZ_DIR     = 8'hD5;

    // XOR of exactly the bytes that will be emitted for an instruction.
    function automatic logic [7:0] instChecksum(input logic [7:0] opcode,
                                                input logic [7:0] operand1,
                                                input logic [7:0] operand2,
                                                input logic [1:0] len);
        logic [7:0] sum;
        sum = opcode;
        if (len == LEN_2 || len == LEN_3) begin
            sum = sum ^ operand1;
        end
        if (len == LEN_3) begin
            sum = sum ^ operand2;
        end
        return sum;
    endfunction

endpackage

// File: rtl/instruction_length_decode.sv
// Combinational 8051 instruction length decoder: opcode in, 1/2/3 out.
// Shared with the fetch path, so it carries no state and no configuration.
module instruction_length_decode
    import instruction_serializer_pkg::*;
(
    input  logic [7:0] opcode_i,
    output logic [1:0] length_o
);

    // Full opcode-map lookup; AJMP/ACALL pages are caught by the low five bits.
    always_comb begin
        length_o = LEN_1;
        case (opcode_i)
            OP_LJMP, OP_JBC, OP_LCALL, OP_JB, OP_JNB,
            OP_ORL_DIR_IMM, OP_ANL_DIR_IMM, OP_XRL_DIR_IMM,
            OP_MOV_DIR_IMM, OP_MOV_DIR_DIR, OP_MOV_DPTR_IMM,
            8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB8, 8'hB9, 8'hBA, 8'hBB,
            8'hBC, 8'hBD, 8'hBE, 8'hBF,
            OP_DJNZ_DIR:
                length_o = LEN_3;

            8'h05, 8'h15,
            8'h24, 8'h25, 8'h34, 8'h35, 8'h94, 8'h95,
            8'h40, 8'h50, 8'h60, 8'h70, 8'h80,
            8'h42, 8'h44, 8'h45, 8'h52, 8'h54, 8'h55,
            8'h62, 8'h64, 8'h65,
            8'h72, 8'h82, 8'h92, 8'hA0, 8'hA2, 8'hB0, 8'hB2,
            8'hC2, 8'hD2,
            8'h74, 8'h76, 8'h77,
            8'h78, 8'h79, 8'h7A, 8'h7B, 8'h7C, 8'h7D, 8'h7E, 8'h7F,
            8'h86, 8'h87,
            8'h88, 8'h89, 8'h8A, 8'h8B, 8'h8C, 8'h8D, 8'h8E, 8'h8F,
            8'hA6, 8'hA7,
            8'hA8, 8'hA9, 8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF,
            8'hC0, 8'hD0, 8'hC5,
            8'hD8, 8'hD9, 8'hDA, 8'hDB, 8'hDC, 8'hDD, 8'hDE, 8'hDF,
            8'hE5, 8'hF5:
                length_o = LEN_2;

            default: begin
                if (opcode_i[4:0] == OP_AJMP_PAGE0[4:0] ||
                    opcode_i[4:0] == OP_ACALL_PAGE0[4:0]) begin
                    length_o = LEN_2;
                end
            end
        endcase
    end

endmodule

// File: rtl/instruction_byte_serializer.sv
// Serializes one parallel 8051 instruction into 1..3 bytes over a
// valid/ready stream, counting completed instructions. Defining
// INST_SERIALIZER_CHECKSUM_EN appends an XOR checksum byte per instruction.
module instruction_byte_serializer
    import instruction_serializer_pkg::*;
#(
    parameter int COUNT_WIDTH = 16
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inst_valid,
    output logic                   inst_ready,
    input  logic [7:0]             inst_opcode,
    input  logic [7:0]             inst_operand1,
    input  logic [7:0]             inst_operand2,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic [7:0]             byte_data,
    output logic                   byte_last,
    output logic [1:0]             inst_length,
    output logic [COUNT_WIDTH-1:0] inst_count
);

`ifdef INST_SERIALIZER_CHECKSUM_EN
    localparam bit ChecksumEn = 1'b1;
`else
    localparam bit ChecksumEn = 1'b0;
`endif

    localparam logic [COUNT_WIDTH-1:0] CountOne = COUNT_WIDTH'(1);

    ser_state_e             state_q, state_d;
    logic [7:0]             operand1_q, operand1_d;
    logic [7:0]             operand2_q, operand2_d;
    logic [1:0]             instLength_q, instLength_d;
    logic                   byteValid_q, byteValid_d;
    logic [7:0]             byteData_q, byteData_d;
    logic                   byteLast_q, byteLast_d;
    logic [COUNT_WIDTH-1:0] instCount_q, instCount_d;
`ifdef INST_SERIALIZER_CHECKSUM_EN
    logic [7:0]             checksum_q, checksum_d;
`endif

    logic [1:0] decodedLen;
    logic       dataDone;
    logic       lastState;
    logic       handshake;
    logic       accept;

    instruction_length_decode u_length_decode (
        .opcode_i (inst_opcode),
        .length_o (decodedLen)
    );

    // Identify the state holding the final byte so a new instruction can be
    // accepted on the same edge that retires the current one.
    always_comb begin
        dataDone = (state_q == ST_B0 && instLength_q == LEN_1) ||
                   (state_q == ST_B1 && instLength_q == LEN_2) ||
                   (state_q == ST_B2);
        if (ChecksumEn) begin
            lastState = (state_q == ST_CHK);
        end else begin
            lastState = dataDone;
        end
        handshake  = byteValid_q && byte_ready;
        inst_ready = (state_q == ST_IDLE) || (lastState && byte_ready);
        accept     = inst_valid && inst_ready;
    end

    // Next-state and next-output logic; an accept overrides the return to idle.
    always_comb begin
        state_d      = state_q;
        operand1_d   = operand1_q;
        operand2_d   = operand2_q;
        instLength_d = instLength_q;
        byteValid_d  = byteValid_q;
        byteData_d   = byteData_q;
        byteLast_d   = byteLast_q;
        instCount_d  = instCount_q;
`ifdef INST_SERIALIZER_CHECKSUM_EN
        checksum_d   = checksum_q;
`endif

        if (handshake && byteLast_q) begin
            instCount_d = instCount_q + CountOne;
        end

        if (handshake) begin
            if (lastState) begin
                state_d      = ST_IDLE;
                byteValid_d  = 1'b0;
                byteData_d   = 8'h00;
                byteLast_d   = 1'b0;
                instLength_d = LEN_0;
            end else if (dataDone) begin
`ifdef INST_SERIALIZER_CHECKSUM_EN
                state_d    = ST_CHK;
                byteData_d = checksum_q;
                byteLast_d = 1'b1;
`endif
            end else if (state_q == ST_B0) begin
                state_d    = ST_B1;
                byteData_d = operand1_q;
                byteLast_d = !ChecksumEn && (instLength_q == LEN_2);
            end else if (state_q == ST_B1) begin
                state_d    = ST_B2;
                byteData_d = operand2_q;
                byteLast_d = !ChecksumEn;
            end
        end

        if (accept) begin
            state_d      = ST_B0;
            operand1_d   = inst_operand1;
            operand2_d   = inst_operand2;
            instLength_d = decodedLen;
            byteValid_d  = 1'b1;
            byteData_d   = inst_opcode;
            byteLast_d   = !ChecksumEn && (decodedLen == LEN_1);
`ifdef INST_SERIALIZER_CHECKSUM_EN
            checksum_d   = instChecksum(inst_opcode, inst_operand1,
                                        inst_operand2, decodedLen);
`endif
        end
    end

    // State and registered outputs; reset drops any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            operand1_q   <= 8'h00;
            operand2_q   <= 8'h00;
            instLength_q <= LEN_0;
            byteValid_q  <= 1'b0;
            byteData_q   <= 8'h00;
            byteLast_q   <= 1'b0;
            instCount_q  <= '0;
`ifdef INST_SERIALIZER_CHECKSUM_EN
            checksum_q   <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            operand1_q   <= operand1_d;
            operand2_q   <= operand2_d;
            instLength_q <= instLength_d;
            byteValid_q  <= byteValid_d;
            byteData_q   <= byteData_d;
            byteLast_q   <= byteLast_d;
            instCount_q  <= instCount_d;
`ifdef INST_SERIALIZER_CHECKSUM_EN
            checksum_q   <= checksum_d;
`endif
        end
    end

    assign byte_valid  = byteValid_q;
    assign byte_data   = byteData_q;
    assign byte_last   = byteLast_q;
    assign inst_length = instLength_q;
    assign inst_count  = instCount_q;

endmodule

// File: tb/tb_instruction_byte_serializer.sv
// Directed bench for instruction_byte_serializer (narrow counter so the
// wrap-around is reachable quickly).
module tb_instruction_byte_serializer;

    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          inst_valid;
    logic          inst_ready;
    logic [7:0]    inst_opcode;
    logic [7:0]    inst_operand1;
    logic [7:0]    inst_operand2;
    logic          byte_valid;
    logic          byte_ready;
    logic [7:0]    byte_data;
    logic          byte_last;
    logic [1:0]    inst_length;
    logic [CW-1:0] inst_count;

    // {inst_ready, byte_valid, byte_last, inst_length, byte_data}
    logic [12:0] snap;
    assign snap = {inst_ready, byte_valid, byte_last, inst_length, byte_data};

    int checks;
    int failures;
    int expCount;

    logic [7:0] lenOps [17] = '{8'h01, 8'h11, 8'hA5, 8'hB4, 8'hBF, 8'hD5, 8'hD8,
                                8'hC5, 8'h80, 8'h00, 8'h85, 8'h43, 8'h42, 8'h92,
                                8'h06, 8'hF1, 8'h23};
    logic [1:0] lenExp [17] = '{2'd2, 2'd2, 2'd1, 2'd3, 2'd3, 2'd3, 2'd2,
                                2'd2, 2'd2, 2'd1, 2'd3, 2'd3, 2'd2, 2'd2,
                                2'd1, 2'd2, 2'd1};

    instruction_byte_serializer #(.COUNT_WIDTH(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_opcode   (inst_opcode),
        .inst_operand1 (inst_operand1),
        .inst_operand2 (inst_operand2),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .byte_data     (byte_data),
        .byte_last     (byte_last),
        .inst_length   (inst_length),
        .inst_count    (inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] op,
                                 input logic [7:0] o1, input logic [7:0] o2);
        inst_valid    = v;
        inst_opcode   = op;
        inst_operand1 = o1;
        inst_operand2 = o2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        byte_ready = 1'b0;
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        repeat (3) tick();
        checks++;
        if (snap !== {1'b1, 1'b0, 1'b0, 2'd0, 8'h00}) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", snap, {1'b1, 1'b0, 1'b0, 2'd0, 8'h00});
        end
        reset = 1'b0;
        tick();
        checks++;
        if (inst_count !== CW'(0) || snap !== {1'b1, 1'b0, 1'b0, 2'd0, 8'h00}) begin
            failures++;
            $display("[TB] FAIL post_reset_idle: got count=%h snap=%h expected count=0 snap=1000", inst_count, snap);
        end
    endtask

    task automatic test_reset_mid();
        byte_ready = 1'b1;
        applyStimulus(1'b1, 8'h90, 8'hAB, 8'hCD);
        tick();
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        checks++;
        if (snap !== {1'b0, 1'b1, 1'b0, 2'd3, 8'h90}) begin
            failures++;
            $display("[TB] FAIL mid_b0: got %h expected %h", snap, {1'b0, 1'b1, 1'b0, 2'd3, 8'h90});
        end
        tick();
        checks++;
        if (snap !== {1'b0, 1'b1, 1'b0, 2'd3, 8'hAB}) begin
            failures++;
            $display("[TB] FAIL mid_b1: got %h expected %h", snap, {1'b0, 1'b1, 1'b0, 2'd3, 8'hAB});
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (snap !== {1'b1, 1'b0, 1'b0, 2'd0, 8'h00} || inst_count !== CW'(expCount)) begin
            failures++;
            $display("[TB] FAIL async_reset_drop: got snap=%h count=%h expected snap=1000 count=%h", snap, inst_count, CW'(expCount));
        end
        tick();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (snap !== {1'b1, 1'b0, 1'b0, 2'd0, 8'h00}) begin
            failures++;
            $display("[TB] FAIL no_partial_after_reset: got %h expected 1000", snap);
        end
    endtask

    task automatic test_single_byte();
        byte_ready = 1'b1;
        applyStimulus(1'b1, 8'h04, 8'h77, 8'h88);
        checks++;
        if (inst_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_ready_idle: got %b expected 1", inst_ready);
        end
        tick();
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        checks++;
        if (snap !== {1'b1, 1'b1, 1'b1, 2'd1, 8'h04}) begin
            failures++;
            $display("[TB] FAIL single_byte: got %h expected %h", snap, {1'b1, 1'b1, 1'b1, 2'd1, 8'h04});
        end
        tick();
        expCount++;
        checks++;
        if (snap !== {1'b1, 1'b0, 1'b0, 2'd0, 8'h00} || inst_count !== CW'(expCount)) begin
            failures++;
            $display("[TB] FAIL single_done: got snap=%h count=%h expected snap=1000 count=%h", snap, inst_count, CW'(expCount));
        end
    endtask

    task automatic test_two_byte();
        byte_ready = 1'b1;
        applyStimulus(1'b1, 8'h74, 8'h5A, 8'h99);
        tick();
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        checks++;
        if (snap !== {1'b0, 1'b1, 1'b0, 2'd2, 8'h74}) begin
            failures++;
            $display("[TB] FAIL two_b0: got %h expected %h", snap, {1'b0, 1'b1, 1'b0, 2'd2, 8'h74});
        end
        tick();
        checks++;
        if (snap !== {1'b1, 1'b1, 1'b1, 2'd2, 8'h5A}) begin
            failures++;
            $display("[TB] FAIL two_b1: got %h expected %h", snap, {1'b1, 1'b1, 1'b1, 2'd2, 8'h5A});
        end
        tick();
        expCount++;
        checks++;
        if (snap !== {1'b1, 1'b0, 1'b0, 2'd0, 8'h00} || inst_count !== CW'(expCount)) begin
            failures++;
            $display("[TB] FAIL two_done: got snap=%h count=%h expected snap=1000 count=%h", snap, inst_count, CW'(expCount));
        end
    endtask

    task automatic test_stall();
        byte_ready = 1'b1;
        applyStimulus(1'b1, 8'h02, 8'h12, 8'h34);
        tick();
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        checks++;
        if (snap !== {1'b0, 1'b1, 1'b0, 2'd3, 8'h02}) begin
            failures++;
            $display("[TB] FAIL ljmp_b0: got %h expected %h", snap, {1'b0, 1'b1, 1'b0, 2'd3, 8'h02});
        end
        tick();
        byte_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (snap !== {1'b0, 1'b1, 1'b0, 2'd3, 8'h12}) begin
                failures++;
                $display("[TB] FAIL ljmp_hold_%0d: got %h expected %h", i, snap, {1'b0, 1'b1, 1'b0, 2'd3, 8'h12});
            end
            if (i < 3) tick();
        end
        byte_ready = 1'b1;
        #1;
        checks++;
        if (inst_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ljmp_ready_b1: got %b expected 0", inst_ready);
        end
        tick();
        checks++;
        if (snap !== {1'b1, 1'b1, 1'b1, 2'd3, 8'h34}) begin
            failures++;
            $display("[TB] FAIL ljmp_b2: got %h expected %h", snap, {1'b1, 1'b1, 1'b1, 2'd3, 8'h34});
        end
        tick();
        expCount++;
        checks++;
        if (snap !== {1'b1, 1'b0, 1'b0, 2'd0, 8'h00} || inst_count !== CW'(expCount)) begin
            failures++;
            $display("[TB] FAIL ljmp_done: got snap=%h count=%h expected snap=1000 count=%h", snap, inst_count, CW'(expCount));
        end
    endtask

    task automatic test_back_to_back();
        byte_ready = 1'b1;
        applyStimulus(1'b1, 8'hE4, 8'h00, 8'h00);
        tick();
        applyStimulus(1'b1, 8'h75, 8'h80, 8'hFF);
        checks++;
        if (snap !== {1'b1, 1'b1, 1'b1, 2'd1, 8'hE4}) begin
            failures++;
            $display("[TB] FAIL b2b_e4: got %h expected %h", snap, {1'b1, 1'b1, 1'b1, 2'd1, 8'hE4});
        end
        tick();
        applyStimulus(1'b1, 8'h00, 8'h00, 8'h00);
        expCount++;
        checks++;
        if (snap !== {1'b0, 1'b1, 1'b0, 2'd3, 8'h75} || inst_count !== CW'(expCount)) begin
            failures++;
            $display("[TB] FAIL b2b_75: got snap=%h count=%h expected snap=%h count=%h", snap, inst_count, {1'b0, 1'b1, 1'b0, 2'd3, 8'h75}, CW'(expCount));
        end
        tick();
        checks++;
        if (snap !== {1'b0, 1'b1, 1'b0, 2'd3, 8'h80}) begin
            failures++;
            $display("[TB] FAIL b2b_80: got %h expected %h", snap, {1'b0, 1'b1, 1'b0, 2'd3, 8'h80});
        end
        tick();
        checks++;
        if (snap !== {1'b1, 1'b1, 1'b1, 2'd3, 8'hFF}) begin
            failures++;
            $display("[TB] FAIL b2b_ff: got %h expected %h", snap, {1'b1, 1'b1, 1'b1, 2'd3, 8'hFF});
        end
        tick();
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        expCount++;
        checks++;
        if (snap !== {1'b1, 1'b1, 1'b1, 2'd1, 8'h00} || inst_count !== CW'(expCount)) begin
            failures++;
            $display("[TB] FAIL b2b_00: got snap=%h count=%h expected snap=%h count=%h", snap, inst_count, {1'b1, 1'b1, 1'b1, 2'd1, 8'h00}, CW'(expCount));
        end
        tick();
        expCount++;
        checks++;
        if (snap !== {1'b1, 1'b0, 1'b0, 2'd0, 8'h00} || inst_count !== CW'(expCount)) begin
            failures++;
            $display("[TB] FAIL b2b_done: got snap=%h count=%h expected snap=1000 count=%h", snap, inst_count, CW'(expCount));
        end
    endtask

    task automatic test_lengths();
        byte_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, lenOps[i], 8'h11, 8'h22);
            tick();
            applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
            checks++;
            if (inst_length !== lenExp[i]) begin
                failures++;
                $display("[TB] FAIL len_%h: got %0d expected %0d", lenOps[i], inst_length, lenExp[i]);
            end
            repeat (int'(lenExp[i]) - 1) tick();
            checks++;
            if ({byte_valid, byte_last} !== 2'b11) begin
                failures++;
                $display("[TB] FAIL len_last_%h: got valid=%b last=%b expected 1 1", lenOps[i], byte_valid, byte_last);
            end
            tick();
            expCount++;
            checks++;
            if ({byte_valid, inst_length} !== 3'b000 || inst_count !== CW'(expCount)) begin
                failures++;
                $display("[TB] FAIL len_done_%h: got valid=%b len=%0d count=%h expected 0 0 %h", lenOps[i], byte_valid, inst_length, inst_count, CW'(expCount));
            end
        end
    endtask

    task automatic test_wrap();
        byte_ready = 1'b1;
        applyStimulus(1'b1, 8'h00, 8'h00, 8'h00);
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            expCount++;
            checks++;
            if (snap !== {1'b1, 1'b1, 1'b1, 2'd1, 8'h00} || inst_count !== CW'(expCount)) begin
                failures++;
                $display("[TB] FAIL wrap_%0d: got snap=%h count=%h expected snap=%h count=%h", i, snap, inst_count, {1'b1, 1'b1, 1'b1, 2'd1, 8'h00}, CW'(expCount));
            end
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        expCount++;
        checks++;
        if (snap !== {1'b1, 1'b0, 1'b0, 2'd0, 8'h00} || inst_count !== CW'(expCount)) begin
            failures++;
            $display("[TB] FAIL wrap_done: got snap=%h count=%h expected snap=1000 count=%h", snap, inst_count, CW'(expCount));
        end
    endtask

    task automatic test_checksum();
        byte_ready = 1'b1;
        applyStimulus(1'b1, 8'h24, 8'h0F, 8'h55);
        tick();
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        checks++;
        if (snap !== {1'b0, 1'b1, 1'b0, 2'd2, 8'h24}) begin
            failures++;
            $display("[TB] FAIL chk_b0: got %h expected %h", snap, {1'b0, 1'b1, 1'b0, 2'd2, 8'h24});
        end
        tick();
        checks++;
        if (snap !== {1'b0, 1'b1, 1'b0, 2'd2, 8'h0F}) begin
            failures++;
            $display("[TB] FAIL chk_b1: got %h expected %h", snap, {1'b0, 1'b1, 1'b0, 2'd2, 8'h0F});
        end
        tick();
        checks++;
        if (snap !== {1'b1, 1'b1, 1'b1, 2'd2, 8'h2B}) begin
            failures++;
            $display("[TB] FAIL chk_byte: got %h expected %h", snap, {1'b1, 1'b1, 1'b1, 2'd2, 8'h2B});
        end
        tick();
        expCount++;
        checks++;
        if (snap !== {1'b1, 1'b0, 1'b0, 2'd0, 8'h00} || inst_count !== CW'(expCount)) begin
            failures++;
            $display("[TB] FAIL chk_done: got snap=%h count=%h expected snap=1000 count=%h", snap, inst_count, CW'(expCount));
        end
    endtask

    // Run all scenarios in order; counter expectations carry across tests.
    initial begin
        checks   = 0;
        failures = 0;
        expCount = 0;
        test_reset();
        test_reset_mid();
`ifdef INST_SERIALIZER_CHECKSUM_EN
        test_checksum();
`else
        test_single_byte();
        test_two_byte();
        test_stall();
        test_back_to_back();
        test_lengths();
        test_wrap();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stuck simulation.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/instruction_byte_serializer.md
# instruction_byte_serializer

Converts one parallel 8051 instruction (opcode plus up to two operand bytes) into a byte stream for the code-memory loader and debug trace port. It is the transmit-side counterpart of the fetch path's instruction-length decode: it derives the instruction length from the opcode and emits exactly 1, 2 or 3 bytes. Both sides use a valid/ready handshake. It sits between the on-chip debugger/loader command unit and the code-RAM write port.

## Interface
Parameters:
- `COUNT_WIDTH`, default 16. Width of the emitted-instruction counter.

Ports:
- `clk`  in  1  Core clock.
- `reset`  in  1  Asynchronous, active-high reset.
- `inst_valid`  in  1  Parallel instruction offered.
- `inst_ready`  out  1  Serializer accepts the instruction this cycle.
- `inst_opcode`  in  8  Opcode byte.
- `inst_operand1`  in  8  First operand. Ignored for 1-byte opcodes.
- `inst_operand2`  in  8  Second operand. Ignored unless length is 3.
- `byte_valid`  out  1  `byte_data` is valid.
- `byte_ready`  in  1  Downstream takes the byte.
- `byte_data`  out  8  Serialized byte.
- `byte_last`  out  1  Marks the final byte of the instruction.
- `inst_length`  out  2  Length of the instruction in flight (1..3). 0 when idle.
- `inst_count`  out  COUNT_WIDTH  Number of instructions fully emitted. Wraps modulo 2^COUNT_WIDTH.

## Operation
Length decode (combinational, on `inst_opcode`):
- 3 bytes: 0x02, 0x10, 0x12, 0x20, 0x30, 0x43, 0x53, 0x63, 0x75, 0x85, 0x90, 0xB4–0xBF, 0xD5.
- 2 bytes: all AJMP/ACALL (`opcode[4:0]` = 0x01 or 0x11), the dir/#data/bit/rel opcodes (ADD/ADDC/SUBB/ANL/ORL/XRL A,dir and A,#data; dir,A forms; bit ops; SJMP, JC, JNC, JZ, JNZ; MOV A/Rn/@Ri/dir forms with one operand; PUSH, POP, XCH A,dir; DJNZ Rn,rel; INC/DEC dir).
- 1 byte: every other opcode, including the reserved 0xA5.

FSM states: IDLE, B0, B1, B2 (plus CHK when configured).
- IDLE: `inst_ready`=1. On `inst_valid`: capture the three bytes and the decoded length, then go to B0.
- B0 emits the opcode, B1 emits operand1, B2 emits operand2.
- A state advances only when `byte_valid && byte_ready`.
- After the last byte of the length, go to IDLE. The exception is a back-to-back accept: `inst_ready` = IDLE or (last-byte state && `byte_ready`). An accept in that cycle goes straight to B0 with the new capture.
- `byte_data` and `byte_last` hold stable while `byte_valid && !byte_ready`.
- `inst_count` increments on the handshake of the byte carrying `byte_last`.
- Reset at any time: drop the in-flight instruction, go to IDLE. No partial bytes are emitted afterwards.

## Timing
- Reset values: `inst_ready`=1, `byte_valid`=0, `byte_data`=0, `byte_last`=0, `inst_length`=0, `inst_count`=0.
- Latency: accept at cycle N gives the first byte valid at N+1.
- With `byte_ready` held high, an L-byte instruction occupies L cycles. Back-to-back instructions stream with no bubbles.
- `inst_ready` is combinational from state and `byte_ready`. All other outputs are registered.
- Simultaneous last-byte handshake and new accept: the counter increments and the new capture both happen in the same cycle.
- `inst_count` wraps from all-ones to 0 without a flag.

## Configuration
- `INST_SERIALIZER_CHECKSUM_EN` defined:
  - After the last instruction byte, state CHK emits one extra byte equal to the XOR of the emitted bytes.
  - `byte_last` moves to the checksum byte.
  - Cycles per instruction become L+1.
  - `inst_length` still reports L.
- Undefined: no CHK state and no checksum byte.

## Structure
- Shared package `instruction_serializer_pkg`:
  - FSM state enum.
  - Length constants `LEN_1`, `LEN_2`, `LEN_3`.
  - 3-byte opcode constants, alongside the existing MCS-51 opcode definitions.
- Sub-module `instruction_length_decode`:
  - Purely combinational, opcode in, 2-bit length out.
  - Reusable by the fetch path.

## Test plan
- Opcode 0x04 (INC A), `byte_ready`=1: one byte 0x04 with `byte_last`=1 at N+1; `inst_count` goes 0→1; `inst_ready` high throughout.
- 0x74 0x5A (MOV A,#0x5A): bytes 0x74, 0x5A; `byte_last` only on 0x5A; `inst_length`=2.
- 0x02 0x12 0x34 (LJMP) with `byte_ready` low for 3 cycles on byte 1: 0x12 is held stable; the sequence completes in 6 cycles; `inst_ready` is low until the last handshake.
- Back-to-back 0xE4, 0x75 0x80 0xFF, 0x00 with `byte_ready`=1: a continuous 5-byte stream with no idle cycle; `inst_count`=3.
- Reset asserted mid-B1 of 0x90 0xAB 0xCD: `byte_valid` drops immediately; idle values restored; `inst_count` unchanged; the next instruction starts cleanly at B0.
- With `INST_SERIALIZER_CHECKSUM_EN`, 0x24 0x0F: bytes 0x24, 0x0F, 0x2B; `byte_last` only on 0x2B.
